sr_flag_arbiter: RTL and testbench

Shared set/reset flag bank with a single write port, arbitrated among NREQ requesters. Each flag follows set-dominant SR flip-flop semantics, next = s | (~r & q). The block accepts one set/reset command per cycle through per-requester valid/ready handshakes. It also sequences a bank-wide flush that clears one flag per cycle. It sits between control agents and any logic that consumes the status flags.

---
 rtl/sr_flag_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/sr_flag_arbiter.sv | 116 +++++++++++
 tb/tb_sr_flag_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_arb_pkg.sv
// Shared types and helpers for the SR flag bank arbiter (state encoding, SR next-state, index widths).
package sr_flag_arb_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int NREQ_DEF  = 4;
    localparam int NFLAG_DEF = 8;

    // Keeps index ports at least one bit wide when a count of one is passed in.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic srff_next(input logic s, input logic r, input logic q);
        return s | (~r & q);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot requester select, combinational from req_i; round-robin when SRF_ARB_FAIR_EN is defined,
// fixed priority (bit 0 highest) otherwise. The pointer only moves when advance_i reports an acceptance.
module rr_arbiter
    import sr_flag_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o
);

`ifdef SRF_ARB_FAIR_EN
    localparam int PW = idx_width(NREQ);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    logic [PW-1:0] nxt;
    logic          found;

    // ptr_q holds the first requester to consider, i.e. one past the last winner.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        sum     = '0;
        cand    = '0;
        nxt     = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            cand = sum[PW-1:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                nxt           = (cand == PW'(NREQ-1)) ? '0 : cand + 1'b1;
            end
        end
        if (advance_i && found) begin
            ptr_d = nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, advance_i};

    // Isolate the lowest set bit.
    assign grant_o = req_i & (~req_i + 1'b1);
`endif

endmodule

// File: rtl/sr_flag_arbiter.sv
// Set-dominant SR flag bank behind an arbitrated single write port; updates and grant echo 1 cycle after accept.
// Backpressure: one req_ready bit at a time, none during flush (NFLAG cycles); SRF_ARB_FAIR_EN selects round-robin.
module sr_flag_arbiter
    import sr_flag_arb_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int NFLAG = NFLAG_DEF,
    localparam int IDXW  = idx_width(NFLAG),
    localparam int GIDW  = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_s,
    input  logic [NREQ-1:0]      req_r,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic                 flush_busy,
    output logic [NFLAG-1:0]     flags,
    output logic                 gnt_valid,
    output logic [GIDW-1:0]      gnt_id
);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;
    logic [NFLAG-1:0]  flags_q, flags_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [GIDW-1:0]   gnt_id_q, gnt_id_d;

    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ready;
    logic [GIDW-1:0]   sel_id;
    logic              sel_s, sel_r;
    logic [IDXW-1:0]   sel_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .advance_i (|ready),
        .grant_o   (grant)
    );

    always_comb begin
        sel_id  = '0;
        sel_s   = 1'b0;
        sel_r   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_id  = GIDW'(k);
                sel_s   = req_s[k];
                sel_r   = req_r[k];
                sel_idx = req_idx[k*IDXW +: IDXW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        gnt_valid_d = 1'b0;
        gnt_id_d    = gnt_id_q;
        ready       = '0;
        case (state_q)
            ST_RUN: begin
                // A flush pulse takes the write port for this cycle, so no grant goes out.
                if (flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (|grant) begin
                    ready            = grant;
                    flags_d[sel_idx] = srff_next(sel_s, sel_r, flags_q[sel_idx]);
                    gnt_valid_d      = 1'b1;
                    gnt_id_d         = sel_id;
                end
            end
            ST_FLUSH: begin
                flags_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == IDXW'(NFLAG-1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            flags_q     <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    assign req_ready  = ready & {NREQ{rst_n}};
    assign flush_busy = (state_q == ST_FLUSH);
    assign flags      = flags_q;
    assign gnt_valid  = gnt_valid_q;
    assign gnt_id     = gnt_id_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter (NREQ=4, NFLAG=8); contention expectations follow SRF_ARB_FAIR_EN.
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_s, req_r;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      req_ready;
    logic                 flush;
    logic                 flush_busy;
    logic [NFLAG-1:0]     flags;
    logic                 gnt_valid;
    logic [1:0]           gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_s      (req_s),
        .req_r      (req_r),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .flush      (flush),
        .flush_busy (flush_busy),
        .flags      (flags),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid = '0;
        req_s     = '0;
        req_r     = '0;
        req_idx   = '0;
        flush     = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 4'($urandom);
        req_s     = 4'($urandom);
        req_r     = 4'($urandom);
        req_idx   = 12'($urandom);
        flush     = 1'($urandom);
        tick();
        tick();
        n_checks++; if (flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags got %h exp 00", flags); end
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_valid got %b exp 0", gnt_valid); end
        n_checks++; if (flush_busy !== 1'b0) begin n_fail++; $display("FAIL reset_flush_busy got %b exp 0", flush_busy); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        n_checks++; if (flags !== 8'h00) begin n_fail++; $display("FAIL idle_flags got %h exp 00", flags); end
        n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_gnt_valid got %b exp 0", gnt_valid); end
    endtask

    task automatic test_single;
        req_valid = 4'b0100;
        req_s[2] = 1'b1; req_r[2] = 1'b0; req_idx[2*IDXW +: IDXW] = 3'd5;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        tick();
        n_checks++; if (flags !== 8'h20) begin n_fail++; $display("FAIL single_set got %h exp 20", flags); end
        n_checks++; if (gnt_valid !== 1'b1 || gnt_id !== 2'd2) begin n_fail++; $display("FAIL single_gnt1 got v=%b id=%0d exp v=1 id=2", gnt_valid, gnt_id); end
        req_s[2] = 1'b0; req_r[2] = 1'b1;
        tick();
        n_checks++; if (flags !== 8'h00) begin n_fail++; $display("FAIL single_reset got %h exp 00", flags); end
        n_checks++; if (gnt_valid !== 1'b1 || gnt_id !== 2'd2) begin n_fail++; $display("FAIL single_gnt2 got v=%b id=%0d exp v=1 id=2", gnt_valid, gnt_id); end
        req_s[2] = 1'b1; req_r[2] = 1'b1; req_idx[2*IDXW +: IDXW] = 3'd3;
        tick();
        n_checks++; if (flags !== 8'h08) begin n_fail++; $display("FAIL single_set_wins got %h exp 08", flags); end
        req_s[2] = 1'b0; req_r[2] = 1'b0;
        tick();
        n_checks++; if (flags !== 8'h08 || gnt_valid !== 1'b1) begin n_fail++; $display("FAIL single_noop got flags=%h v=%b exp flags=08 v=1", flags, gnt_valid); end
        idle_inputs();
        tick();
        n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got v=%b exp 0", gnt_valid); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_id [5];
        logic [7:0] exp_flags;
        logic [3:0] exp_rdy;
`ifdef SRF_ARB_FAIR_EN
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_flags = 8'h0F;
`else
        exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_flags = 8'h01;
`endif
        apply_reset();
        req_valid = 4'hF;
        req_s     = 4'hF;
        for (int k = 0; k < NREQ; k++) req_idx[k*IDXW +: IDXW] = 3'(k);
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_rdy = 4'b0001 << exp_id[c];
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL contention_ready c=%0d got %b exp %b", c, req_ready, exp_rdy); end
            tick();
            n_checks++; if (gnt_valid !== 1'b1 || gnt_id !== exp_id[c]) begin n_fail++; $display("FAIL contention_gnt c=%0d got v=%b id=%0d exp v=1 id=%0d", c, gnt_valid, gnt_id, exp_id[c]); end
        end
        n_checks++; if (flags !== exp_flags) begin n_fail++; $display("FAIL contention_flags got %h exp %h", flags, exp_flags); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush;
        logic [7:0] exp_f;
        req_valid = 4'b0001;
        req_s[0]  = 1'b1;
        for (int i = 0; i < NFLAG; i++) begin
            req_idx[0 +: IDXW] = 3'(i);
            tick();
        end
        idle_inputs();
        tick();
        n_checks++; if (flags !== 8'hFF) begin n_fail++; $display("FAIL flush_fill got %h exp ff", flags); end
        flush     = 1'b1;
        req_valid = 4'b0010;
        req_s[1]  = 1'b1;
        req_idx[1*IDXW +: IDXW] = 3'd2;
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL flush_cycle0_ready got %b exp 0000", req_ready); end
        tick();
        flush = 1'b0;
        n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_grant got v=%b exp 0", gnt_valid); end
        for (int i = 0; i < NFLAG; i++) begin
            exp_f = 8'hFF << i;
            n_checks++; if (flush_busy !== 1'b1 || req_ready !== 4'h0 || flags !== exp_f) begin
                n_fail++; $display("FAIL flush_step i=%0d got busy=%b rdy=%b flags=%h exp busy=1 rdy=0000 flags=%h", i, flush_busy, req_ready, flags, exp_f);
            end
            tick();
        end
        n_checks++; if (flush_busy !== 1'b0 || flags !== 8'h00 || req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL flush_done got busy=%b flags=%h rdy=%b exp busy=0 flags=00 rdy=0010", flush_busy, flags, req_ready);
        end
        tick();
        n_checks++; if (flags !== 8'h04 || gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin
            n_fail++; $display("FAIL flush_after_accept got flags=%h v=%b id=%0d exp flags=04 v=1 id=1", flags, gnt_valid, gnt_id);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_repulse;
        int busy_cycles;
        busy_cycles = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (flush_busy === 1'b1) busy_cycles++;
            flush = (c == 2 || c == 5);
            tick();
        end
        flush = 1'b0;
        n_checks++; if (busy_cycles !== NFLAG) begin n_fail++; $display("FAIL flush_repulse_len got %0d exp %0d", busy_cycles, NFLAG); end
    endtask

    task automatic test_reset_mid_flush;
        req_valid = 4'b0001; req_s[0] = 1'b1; req_idx[0 +: IDXW] = 3'd6;
        tick();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        n_checks++; if (flush_busy !== 1'b1 || flags !== 8'h40) begin n_fail++; $display("FAIL midflush_pre got busy=%b flags=%h exp busy=1 flags=40", flush_busy, flags); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (flush_busy !== 1'b0 || flags !== 8'h00 || req_ready !== 4'h0) begin
            n_fail++; $display("FAIL midflush_reset got busy=%b flags=%h rdy=%b exp busy=0 flags=00 rdy=0000", flush_busy, flags, req_ready);
        end
        rst_n = 1'b1;
        req_valid = 4'b1000; req_s[3] = 1'b1; req_idx[3*IDXW +: IDXW] = 3'd1;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL midflush_release_ready got %b exp 1000", req_ready); end
        tick();
        n_checks++; if (flags !== 8'h02 || gnt_valid !== 1'b1 || gnt_id !== 2'd3) begin
            n_fail++; $display("FAIL midflush_accept got flags=%h v=%b id=%0d exp flags=02 v=1 id=3", flags, gnt_valid, gnt_id);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_flush();
        test_flush_repulse();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
